// File: rtl/letc_core_icache_if.sv
// Fetch-side request/response, flush and backing word-read signals of the instruction cache.
// The slave modport is the cache's view; master is the core/memory side that drives it.
interface letc_core_icache_if;
    logic        i_imem_req_valid;
    logic [31:0] i_imem_req_addr;
    logic        o_imem_rsp_ready;
    logic [31:0] o_imem_rsp_data;
    logic        o_imem_rsp_illegal;
    logic        i_flush;
    logic        o_mem_req_valid;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_rsp_ready;
    logic [31:0] i_mem_rsp_data;
    logic        i_mem_rsp_illegal;

    modport slave (
        input  i_imem_req_valid,
        input  i_imem_req_addr,
        output o_imem_rsp_ready,
        output o_imem_rsp_data,
        output o_imem_rsp_illegal,
        input  i_flush,
        output o_mem_req_valid,
        output o_mem_req_addr,
        input  i_mem_rsp_ready,
        input  i_mem_rsp_data,
        input  i_mem_rsp_illegal
    );

    modport master (
        output i_imem_req_valid,
        output i_imem_req_addr,
        input  o_imem_rsp_ready,
        input  o_imem_rsp_data,
        input  o_imem_rsp_illegal,
        output i_flush,
        input  o_mem_req_valid,
        input  o_mem_req_addr,
        output i_mem_rsp_ready,
        output i_mem_rsp_data,
        output i_mem_rsp_illegal
    );
endinterface

// File: rtl/letc_core_icache.sv
// Direct-mapped read-only instruction cache: combinational hits, whole-line refill from a
// backing word port, one-shot illegal response on misalignment or backing fault.
module letc_core_icache #(
    parameter int unsigned NUM_LINES  = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input logic               clk,
    input logic               rst,
    letc_core_icache_if.slave bus
);
    localparam int unsigned OFS_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 30 - OFS_W - IDX_W;

    typedef enum logic [1:0] {StIdle, StRefill, StFault} state_e;

    state_e           state_q, state_d;
    logic [OFS_W-1:0] beat_q, beat_d;
    logic             flush_pending_q, flush_pending_d;
    logic [IDX_W-1:0] miss_idx_q, miss_idx_d;
    logic [TAG_W-1:0] miss_tag_q, miss_tag_d;
    logic [NUM_LINES-1:0] valid_q, valid_d;

    // Tag and data arrays carry no reset; only the valid bits do.
    logic [TAG_W-1:0] tag_q  [NUM_LINES];
    logic [31:0]      data_q [NUM_LINES*LINE_WORDS];
    logic             tag_we;
    logic             data_we;

    logic [OFS_W-1:0] req_ofs;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_misaligned;
    logic             req_hit;
    logic [31:0]      hit_word;

    assign req_ofs        = bus.i_imem_req_addr[OFS_W+1:2];
    assign req_idx        = bus.i_imem_req_addr[IDX_W+OFS_W+1:OFS_W+2];
    assign req_tag        = bus.i_imem_req_addr[31:IDX_W+OFS_W+2];
    assign req_misaligned = bus.i_imem_req_addr[1:0] != 2'b00;
    assign req_hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign hit_word       = data_q[{req_idx, req_ofs}];

    always_comb begin
        state_d                = state_q;
        beat_d                 = beat_q;
        flush_pending_d        = flush_pending_q;
        miss_idx_d             = miss_idx_q;
        miss_tag_d             = miss_tag_q;
        valid_d                = valid_q;
        tag_we                 = 1'b0;
        data_we                = 1'b0;
        bus.o_imem_rsp_ready   = 1'b0;
        bus.o_imem_rsp_data    = '0;
        bus.o_imem_rsp_illegal = 1'b0;
        bus.o_mem_req_valid    = 1'b0;
        bus.o_mem_req_addr     = '0;

        unique case (state_q)
            StIdle: begin
                if (bus.i_imem_req_valid) begin
                    if (req_misaligned) begin
                        bus.o_imem_rsp_ready   = 1'b1;
                        bus.o_imem_rsp_illegal = 1'b1;
                    end else if (req_hit) begin
                        bus.o_imem_rsp_ready = 1'b1;
                        bus.o_imem_rsp_data  = hit_word;
                    end else begin
                        // Line is invalidated up front so a faulted refill cannot leave a
                        // valid line holding partially overwritten data.
                        miss_idx_d       = req_idx;
                        miss_tag_d       = req_tag;
                        beat_d           = '0;
                        valid_d[req_idx] = 1'b0;
                        state_d          = StRefill;
                    end
                end
            end
            StRefill: begin
                bus.o_mem_req_valid = 1'b1;
                bus.o_mem_req_addr  = {miss_tag_q, miss_idx_q, beat_q, 2'b00};
                if (bus.i_flush) begin
                    flush_pending_d = 1'b1;
                end
                if (bus.i_mem_rsp_ready) begin
                    if (bus.i_mem_rsp_illegal) begin
                        state_d         = StFault;
                        beat_d          = '0;
                        flush_pending_d = 1'b0;
                    end else begin
                        data_we = 1'b1;
                        beat_d  = beat_q + 1'b1;
                        // LINE_WORDS is a power of two, so the last beat is all ones.
                        if (&beat_q) begin
                            state_d         = StIdle;
                            flush_pending_d = 1'b0;
                            if (!flush_pending_q && !bus.i_flush) begin
                                valid_d[miss_idx_q] = 1'b1;
                                tag_we              = 1'b1;
                            end
                        end
                    end
                end
            end
            StFault: begin
                bus.o_imem_rsp_ready   = 1'b1;
                bus.o_imem_rsp_illegal = 1'b1;
                state_d                = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (bus.i_flush) begin
            valid_d = '0;
        end

        if (rst) begin
            bus.o_imem_rsp_ready   = 1'b0;
            bus.o_imem_rsp_data    = '0;
            bus.o_imem_rsp_illegal = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            beat_q          <= '0;
            flush_pending_q <= 1'b0;
            miss_idx_q      <= '0;
            miss_tag_q      <= '0;
            valid_q         <= '0;
        end else begin
            state_q         <= state_d;
            beat_q          <= beat_d;
            flush_pending_q <= flush_pending_d;
            miss_idx_q      <= miss_idx_d;
            miss_tag_q      <= miss_tag_d;
            valid_q         <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && data_we) begin
            data_q[{miss_idx_q, beat_q}] <= bus.i_mem_rsp_data;
        end
        if (!rst && tag_we) begin
            tag_q[miss_idx_q] <= miss_tag_q;
        end
    end
endmodule

// File: tb/tb_letc_core_icache.sv
// Randomised bench for letc_core_icache against a transaction-level cache model built from
// line numbers and per-line word arrays, with a backing memory that returns 0xA000_0000 | addr.
module tb_letc_core_icache;
    localparam int NL = 16;
    localparam int LW = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    letc_core_icache_if bus ();

    letc_core_icache #(
        .NUM_LINES  (NL),
        .LINE_WORDS (LW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: which memory line each cache slot holds and its words.
    bit          m_valid [NL];
    int unsigned m_line  [NL];
    logic [31:0] m_data  [NL][LW];

    function automatic logic [31:0] bmem(input logic [31:0] a);
        return 32'hA000_0000 | a;
    endfunction

    function automatic int unsigned line_of(input logic [31:0] a);
        return a / (4 * LW);
    endfunction

    function automatic int slot_of(input logic [31:0] a);
        return int'(line_of(a) % NL);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % LW);
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return m_valid[slot_of(a)] && (m_line[slot_of(a)] == line_of(a));
    endfunction

    task automatic m_flush_all();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One backing beat at word address a, preceded by 'waits' stall cycles.
    task automatic do_beat(input logic [31:0] a, input int waits, input bit ill, input bit fl);
        for (int w = 0; w < waits; w++) begin
            bus.i_mem_rsp_ready   = 1'b0;
            bus.i_mem_rsp_data    = $urandom;
            bus.i_mem_rsp_illegal = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("wait_mem_valid", 32'(bus.o_mem_req_valid), 32'd1);
            check("wait_mem_addr", bus.o_mem_req_addr, a);
            check("wait_rsp_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
            step();
        end
        bus.i_mem_rsp_ready   = 1'b1;
        bus.i_mem_rsp_data    = bmem(a);
        bus.i_mem_rsp_illegal = ill;
        bus.i_flush           = fl;
        @(negedge clk);
        check("beat_mem_valid", 32'(bus.o_mem_req_valid), 32'd1);
        check("beat_mem_addr", bus.o_mem_req_addr, a);
        check("beat_rsp_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
        step();
        bus.i_mem_rsp_ready   = 1'b0;
        bus.i_mem_rsp_illegal = 1'b0;
        bus.i_flush           = 1'b0;
    endtask

    // Full fetch transaction. fault_beat/flush_at = -1 for none; flush_at = -2 flushes in the
    // request cycle. Both only apply to the first refill attempt.
    task automatic fetch(input logic [31:0] a, input int waits, input int fault_beat,
                         input int flush_at);
        logic [31:0] base;
        bit          flushed;
        base                 = a & ~32'(4 * LW - 1);
        bus.i_imem_req_valid = 1'b1;
        bus.i_imem_req_addr  = a;
        bus.i_flush          = (flush_at == -2);
        for (int att = 0; att < 3; att++) begin
            @(negedge clk);
            if (a[1:0] != 2'b00) begin
                check("misal_ready", 32'(bus.o_imem_rsp_ready), 32'd1);
                check("misal_illegal", 32'(bus.o_imem_rsp_illegal), 32'd1);
                check("misal_data", bus.o_imem_rsp_data, 32'd0);
                check("misal_mem_valid", 32'(bus.o_mem_req_valid), 32'd0);
                if (bus.i_flush) m_flush_all();
                step();
                bus.i_flush          = 1'b0;
                bus.i_imem_req_valid = 1'b0;
                return;
            end
            if (m_hit(a)) begin
                check("hit_ready", 32'(bus.o_imem_rsp_ready), 32'd1);
                check("hit_illegal", 32'(bus.o_imem_rsp_illegal), 32'd0);
                check("hit_data", bus.o_imem_rsp_data, m_data[slot_of(a)][word_of(a)]);
                if (bus.i_flush) m_flush_all();
                step();
                bus.i_flush          = 1'b0;
                bus.i_imem_req_valid = 1'b0;
                return;
            end
            check("miss_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
            if (bus.i_flush) m_flush_all();
            m_valid[slot_of(a)] = 1'b0;
            step();
            bus.i_flush = 1'b0;
            flushed     = 1'b0;
            for (int b = 0; b < LW; b++) begin
                bit ill;
                bit fl;
                ill = (att == 0) && (b == fault_beat);
                fl  = (att == 0) && (b == flush_at);
                do_beat(base + 32'(4 * b), waits, ill, fl);
                if (fl) begin
                    m_flush_all();
                    flushed = 1'b1;
                end
                if (ill) begin
                    @(negedge clk);
                    check("fault_ready", 32'(bus.o_imem_rsp_ready), 32'd1);
                    check("fault_illegal", 32'(bus.o_imem_rsp_illegal), 32'd1);
                    check("fault_data", bus.o_imem_rsp_data, 32'd0);
                    check("fault_mem_valid", 32'(bus.o_mem_req_valid), 32'd0);
                    step();
                    bus.i_imem_req_valid = 1'b0;
                    return;
                end
                m_data[slot_of(a)][b] = bmem(base + 32'(4 * b));
            end
            if (!flushed) begin
                m_valid[slot_of(a)] = 1'b1;
                m_line[slot_of(a)]  = line_of(a);
            end
        end
        check("fetch_completes", 32'd0, 32'd1);
        bus.i_imem_req_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        int          fb;
        int          fl;
        n_vec                 = 0;
        n_err                 = 0;
        rst                   = 1'b1;
        bus.i_imem_req_valid  = 1'b1;
        bus.i_imem_req_addr   = 32'h0000_0102;
        bus.i_flush           = 1'b0;
        bus.i_mem_rsp_ready   = 1'b0;
        bus.i_mem_rsp_data    = '0;
        bus.i_mem_rsp_illegal = 1'b0;
        m_flush_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rsp_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
        check("rst_rsp_illegal", 32'(bus.o_imem_rsp_illegal), 32'd0);
        check("rst_rsp_data", bus.o_imem_rsp_data, 32'd0);
        check("rst_mem_valid", 32'(bus.o_mem_req_valid), 32'd0);
        check("rst_mem_addr", bus.o_mem_req_addr, 32'd0);
        step();
        rst                  = 1'b0;
        bus.i_imem_req_valid = 1'b0;
        step();

        // Cold miss then hit, conflict eviction, backing fault, misaligned fetch.
        fetch(32'h0000_0104, 0, -1, -1);
        fetch(32'h0000_010C, 0, -1, -1);
        fetch(32'h0000_0204, 0, -1, -1);
        fetch(32'h0000_0104, 0, -1, -1);
        fetch(32'h0000_0300, 0, 2, -1);
        fetch(32'h0000_0300, 0, -1, -1);
        fetch(32'h0000_0102, 0, -1, -1);

        // Flush during refill, then a previously valid line must miss.
        fetch(32'h0000_0400, 0, -1, 1);
        fetch(32'h0000_0104, 0, -1, -1);
        fetch(32'h0000_0400, 0, -1, -1);
        fetch(32'h0000_0400, 0, -1, -2);
        fetch(32'h0000_0408, 1, -1, 3);

        // Reset mid-refill with two stall cycles per beat.
        bus.i_imem_req_valid = 1'b1;
        bus.i_imem_req_addr  = 32'h0000_0500;
        @(negedge clk);
        check("rr_miss_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
        step();
        do_beat(32'h0000_0500, 2, 1'b0, 1'b0);
        do_beat(32'h0000_0504, 2, 1'b0, 1'b0);
        rst                 = 1'b1;
        bus.i_mem_rsp_ready = 1'b1;
        bus.i_mem_rsp_data  = bmem(32'h0000_0508);
        @(negedge clk);
        check("rr_rsp_ready", 32'(bus.o_imem_rsp_ready), 32'd0);
        step();
        bus.i_mem_rsp_ready = 1'b0;
        @(negedge clk);
        check("rr_mem_valid", 32'(bus.o_mem_req_valid), 32'd0);
        check("rr_rsp_ready2", 32'(bus.o_imem_rsp_ready), 32'd0);
        check("rr_rsp_illegal", 32'(bus.o_imem_rsp_illegal), 32'd0);
        check("rr_rsp_data", bus.o_imem_rsp_data, 32'd0);
        step();
        rst                  = 1'b0;
        bus.i_imem_req_valid = 1'b0;
        m_flush_all();
        step();
        fetch(32'h0000_0500, 0, -1, -1);
        fetch(32'h0000_010C, 0, -1, -1);

        // Random traffic over a few conflicting tags, including a tag beyond bit 16.
        for (int n = 0; n < 80; n++) begin
            int unsigned tsel;
            tsel = $urandom_range(0, 4);
            a    = ((tsel == 4) ? 32'h0001_0000 : 32'(tsel << 8))
                 | 32'($urandom_range(0, 3) << 4) | 32'($urandom_range(0, 3) << 2);
            if ($urandom_range(0, 9) == 0) a[1:0] = 2'($urandom_range(1, 3));
            fb = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, LW - 1)) : -1;
            case ($urandom_range(0, 9))
                0:       fl = int'($urandom_range(0, LW - 1));
                1:       fl = -2;
                default: fl = -1;
            endcase
            fetch(a, int'($urandom_range(0, 2)), fb, fl);
            if ($urandom_range(0, 3) == 0) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
